// File: rtl/tmds_channel_deskew.sv
// Inter-channel deskew for NCH word-aligned TMDS lanes: polarity fix, blank-end arrival
// measurement, per-lane delay equalisation and lock/realign supervision.
module tmds_channel_deskew #(
  parameter int              NCH      = 3,
  parameter int              MAX_SKEW = 7,
  parameter int              MIN_CTL  = 8,
  parameter int              LOCK_CNT = 4,
  parameter logic [NCH-1:0]  INV_MASK = '0,
  localparam int             DW       = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  input  logic [10*NCH-1:0]   in_data_i,
  input  logic                realign_i,
  output logic                out_valid_o,
  output logic [10*NCH-1:0]   out_data_o,
  output logic                aligned_o,
  output logic                skew_err_o,
  output logic [NCH*DW-1:0]   lane_dly_o
);

  localparam int RW   = $clog2(MIN_CTL + 1);
  localparam int CW   = $clog2(MAX_SKEW + 2);
  localparam int HW   = $clog2(LOCK_CNT + 1);
  localparam int DL_D = (MAX_SKEW > 0) ? MAX_SKEW : 1;
  localparam logic [RW-1:0] RUN_SAT = RW'(MIN_CTL);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  function automatic logic is_ctl(input logic [9:0] wd);
    return (wd == 10'h354) || (wd == 10'h0AB) || (wd == 10'h154) || (wd == 10'h2AB);
  endfunction

  function automatic logic [RW-1:0] run_next(input logic [RW-1:0] run, input logic ctl);
    if (!ctl)           return '0;
    if (run == RUN_SAT) return run;
    return run + 1'b1;
  endfunction

  logic [9:0]    w      [NCH];
  logic [9:0]    tap    [NCH];
  logic [9:0]    dl_q   [NCH][DL_D];
  logic [RW-1:0] irun_q [NCH];
  logic [RW-1:0] irun_d [NCH];
  logic [RW-1:0] orun_q [NCH];
  logic [RW-1:0] orun_d [NCH];
  logic [NCH-1:0] ibe, obe;

  logic [DW-1:0] dly_q [NCH];
  logic [DW-1:0] dly_d [NCH];
  logic [CW-1:0] arr_q [NCH];
  logic [CW-1:0] arr_d [NCH];
  logic [NCH-1:0] arrived_q, arrived_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_n, amax;
  logic [HW-1:0]  hits_q, hits_d;
  state_e         state_q, state_d;
  logic           err_d, skew_err_q;

  logic               out_valid_q;
  logic [10*NCH-1:0]  out_data_q;

  // Input-side words feed arrival measurement; tap-side words feed coincidence checking.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w[c]   = in_data_i[10*c +: 10] ^ {10{INV_MASK[c]}};
      tap[c] = w[c];
      for (int i = 1; i <= MAX_SKEW; i++) begin
        if (dly_q[c] == DW'(i)) tap[c] = dl_q[c][i-1];
      end
      ibe[c]    = in_valid_i && !is_ctl(w[c])   && (irun_q[c] == RUN_SAT);
      obe[c]    = in_valid_i && !is_ctl(tap[c]) && (orun_q[c] == RUN_SAT);
      irun_d[c] = in_valid_i ? run_next(irun_q[c], is_ctl(w[c]))   : irun_q[c];
      orun_d[c] = in_valid_i ? run_next(orun_q[c], is_ctl(tap[c])) : orun_q[c];
    end
  end

  // NOTE: delay-line contents are don't-care after reset, so this plain storage carries no reset.
  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      for (int c = 0; c < NCH; c++) begin
        dl_q[c][0] <= w[c];
        for (int i = 1; i < DL_D; i++) dl_q[c][i] <= dl_q[c][i-1];
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        irun_q[c] <= '0;
        orun_q[c] <= '0;
      end
    end else begin
      out_valid_q <= in_valid_i;
      for (int c = 0; c < NCH; c++) begin
        if (in_valid_i) out_data_q[10*c +: 10] <= tap[c];
        irun_q[c] <= irun_d[c];
        orun_q[c] <= orun_d[c];
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hits_d    = hits_q;
    arr_d     = arr_q;
    arrived_d = arrived_q;
    dly_d     = dly_q;
    err_d     = 1'b0;
    cnt_n     = cnt_q + 1'b1;
    amax      = '0;

    if (realign_i) begin
      state_d = ST_SEARCH;
    end else if (in_valid_i) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (|ibe) begin
            cnt_d     = '0;
            arrived_d = ibe;
            for (int c = 0; c < NCH; c++) arr_d[c] = '0;
            state_d   = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          cnt_d = cnt_n;
          if (cnt_n <= CW'(MAX_SKEW)) begin
            for (int c = 0; c < NCH; c++) begin
              if (ibe[c] && !arrived_q[c]) begin
                arrived_d[c] = 1'b1;
                arr_d[c]     = cnt_n;
              end
            end
          end
          if (&arrived_d) begin
            for (int c = 0; c < NCH; c++) if (arr_d[c] > amax) amax = arr_d[c];
            for (int c = 0; c < NCH; c++) dly_d[c] = DW'(amax - arr_d[c]);
            hits_d  = '0;
            state_d = ST_VERIFY;
          end else if (cnt_n > CW'(MAX_SKEW)) begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
          end
        end
        ST_VERIFY: begin
          if (&obe) begin
            hits_d = hits_q + 1'b1;
            if (hits_d == HW'(LOCK_CNT)) state_d = ST_LOCKED;
          end else if (|obe) begin
            state_d = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (|obe && !(&obe)) begin
            err_d   = 1'b1;
            state_d = ST_SEARCH;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_SEARCH;
      cnt_q      <= '0;
      hits_q     <= '0;
      arrived_q  <= '0;
      skew_err_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        arr_q[c] <= '0;
        dly_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hits_q     <= hits_d;
      arrived_q  <= arrived_d;
      skew_err_q <= err_d;
      arr_q      <= arr_d;
      dly_q      <= dly_d;
    end
  end

  always_comb begin
    lane_dly_o = '0;
    for (int c = 0; c < NCH; c++) lane_dly_o[DW*c +: DW] = dly_q[c];
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign aligned_o   = (state_q == ST_LOCKED);
  assign skew_err_o  = skew_err_q;

endmodule
